// File: rtl/shift_register_universal.sv
// shift_register_universal: N-bit universal register (hold / load / shift left / shift right)
// with serial in/out, a count of loaded bits still to be shifted out, and a one-cycle
// `done` pulse when the last loaded bit leaves.
// Optional feature macro: SHIFT_REGISTER_ROTATE_EN adds the `rot` input (rotate instead of
// inserting sin on shifts).
module shift_register_universal #(
  parameter  int N     = 8,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     din,
  input  logic             sin,
`ifdef SHIFT_REGISTER_ROTATE_EN
  input  logic             rot,
`endif
  output logic [N-1:0]     q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             done
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_SHR  = 2'b11
  } mode_e;

  logic         ins_l;
  logic         ins_r;
  logic [N-1:0] q_shl;
  logic [N-1:0] q_shr;

  // Select the bit entering the register on each shift direction
  always_comb begin
    ins_l = sin;
    ins_r = sin;
`ifdef SHIFT_REGISTER_ROTATE_EN
    if (rot) begin
      ins_l = q[N-1];
      ins_r = q[0];
    end
`endif
    q_shl = {q[N-2:0], ins_l};
    q_shr = {ins_r, q[N-1:1]};
  end

  // Register, bit counter and done pulse; X or hold mode keeps state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      case (mode)
        MODE_LOAD: begin
          q     <= din;
          count <= CNT_W'(N);
          done  <= 1'b0;
        end
        MODE_SHL, MODE_SHR: begin
          q     <= (mode == MODE_SHL) ? q_shl : q_shr;
          // Saturate at zero; done marks only the 1->0 transition
          if (count != '0) count <= count - CNT_W'(1);
          done  <= (count == CNT_W'(1));
        end
        default: begin
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign sout_l = q[N-1];
  assign sout_r = q[0];
  assign empty  = (count == '0);

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench for shift_register_universal (N=8): directed test-plan sequences
// followed by randomized traffic, all compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_shift_register_universal;

  localparam int N     = 8;
  localparam int CNT_W = $clog2(N + 1);
  localparam int MASK  = (1 << N) - 1;

  logic             clk;
  logic             rst;
  logic [1:0]       mode;
  logic [N-1:0]     din;
  logic             sin;
  logic             rot;
  logic [N-1:0]     q;
  logic             sout_l;
  logic             sout_r;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             done;

  shift_register_universal #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .din    (din),
    .sin    (sin),
`ifdef SHIFT_REGISTER_ROTATE_EN
    .rot    (rot),
`endif
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .count  (count),
    .empty  (empty),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register value as an integer, bits remaining, done flag
  int unsigned m_q;
  int unsigned m_cnt;
  bit          m_done;
  int unsigned n_chk;
  int unsigned n_pass;
  int unsigned done_seen;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"},      32'(q),      m_q);
    check({tag, ".count"},  32'(count),  m_cnt);
    check({tag, ".empty"},  32'(empty),  32'(m_cnt == 0));
    check({tag, ".done"},   32'(done),   32'(m_done));
    check({tag, ".sout_l"}, 32'(sout_l), (m_q >> (N - 1)) & 1);
    check({tag, ".sout_r"}, 32'(sout_r), m_q & 1);
  endtask

  task automatic model_reset();
    m_q = 0; m_cnt = 0; m_done = 0;
  endtask

  task automatic model_apply(input logic [1:0] md, input logic [N-1:0] d, input logic s, input logic r);
    int unsigned in_bit;
    bit          rot_on;
`ifdef SHIFT_REGISTER_ROTATE_EN
    rot_on = (r === 1'b1);
`else
    rot_on = 1'b0;
`endif
    case (md)
      2'd1: begin m_q = 32'(d); m_cnt = N; m_done = 0; end
      2'd2: begin
        in_bit = rot_on ? (m_q >> (N - 1)) & 1 : 32'(s);
        m_q    = ((m_q * 2) + in_bit) & MASK;
        m_done = (m_cnt == 1);
        if (m_cnt > 0) m_cnt--;
      end
      2'd3: begin
        in_bit = rot_on ? m_q & 1 : 32'(s);
        m_q    = (m_q / 2) + in_bit * (1 << (N - 1));
        m_done = (m_cnt == 1);
        if (m_cnt > 0) m_cnt--;
      end
      default: m_done = 0;
    endcase
  endtask

  // Drive one cycle, update the model at the edge, compare 1ns later
  task automatic step(input string tag, input logic [1:0] md, input logic [N-1:0] d,
                      input logic s, input logic r);
    mode = md; din = d; sin = s; rot = r;
    @(posedge clk);
    model_apply(md, d, s, r);
    #1;
    if (done === 1'b1) done_seen++;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  logic [N-1:0] pat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0; done_seen = 0;
    rst = 1'b1; mode = 2'b00; din = '0; sin = 1'b0; rot = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Async reset between edges, no clock edge needed
    step("ar_load", 2'd1, 8'hA5, 1'b0, 1'b0);
    async_reset("ar");

    // PISO left: sout_l before each edge must follow B4 MSB-first
    step("piso_load", 2'd1, 8'hB4, 1'b0, 1'b0);
    pat = 8'hB4;
    done_seen = 0;
    for (int i = 0; i < N; i++) begin
      check("piso_sout_l_pre", 32'(sout_l), 32'(pat[N-1-i]));
      step("piso", 2'd2, '0, 1'b0, 1'b0);
    end
    check("piso_q_final", 32'(q), 32'h0);
    check("piso_done_final", 32'(done), 32'h1);
    check("piso_done_once", done_seen, 1);

    // SIPO right: 1,0,0,0,0,0,0,1 -> 81
    step("sipo_load", 2'd1, 8'h00, 1'b0, 1'b0);
    pat = 8'h81;
    done_seen = 0;
    for (int i = 0; i < N; i++) step("sipo", 2'd3, '0, pat[i], 1'b0);
    check("sipo_q", 32'(q), 32'h81);
    check("sipo_done_once", done_seen, 1);

    // Saturation after empty, then reload
    done_seen = 0;
    for (int i = 0; i < 3; i++) step("sat", 2'(2 + (i % 2)), '0, 1'b1, 1'b0);
    check("sat_count", 32'(count), 32'h0);
    check("sat_done_none", done_seen, 0);
    step("reload", 2'd1, 8'h3C, 1'b0, 1'b0);
    check("reload_q", 32'(q), 32'h3C);

    // Hold interrupting a shift sequence
    step("hold_load", 2'd1, 8'hF0, 1'b0, 1'b0);
    step("hold_sh", 2'd2, '0, 1'b0, 1'b0);
    step("hold_sh", 2'd2, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("hold", 2'd0, 8'hFF, 1'b1, 1'b1);
    step("hold_sh3", 2'd2, '0, 1'b0, 1'b0);
    check("hold_q", 32'(q), 32'h80);
    check("hold_count", 32'(count), 32'h5);

`ifdef SHIFT_REGISTER_ROTATE_EN
    step("rot_load", 2'd1, 8'h81, 1'b0, 1'b0);
    done_seen = 0;
    step("rot_r", 2'd3, '0, 1'b0, 1'b1);
    check("rot_r_q", 32'(q), 32'hC0);
    for (int i = 0; i < N; i++) step("rot_l", 2'd2, '0, 1'b0, 1'b1);
    check("rot_l_q", 32'(q), 32'hC0);
    check("rot_done_once", done_seen, 1);
`endif

    // Randomized traffic, loads biased up so counts run through the full range
    for (int i = 0; i < 400; i++) begin
      logic [1:0] md;
      md = ($urandom_range(0, 5) == 0) ? 2'd1 : 2'($urandom_range(0, 3));
      step("rand", md, N'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 40) == 0) async_reset("rand_ar");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_register_universal.md
Name: shift_register_universal

Overview:
- Parametrised N-bit universal register: hold, parallel load, shift left, shift right.
- Serial in/out for parallel-to-serial and serial-to-parallel conversion.
- Tracks bits remaining since the last load and pulses `done` when the loaded word has been fully shifted out.
- Sits between parallel datapaths and serial links (SPI/UART-style shifters, LED chains).

Parameters:
- N, 8, register width in bits; legal range N >= 2.
- CNT_W, $clog2(N+1), width of the bit counter; local parameter, not overridable.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- mode  input  2  operation select: 00 hold, 01 parallel load, 10 shift left (toward MSB), 11 shift right (toward LSB).
- din  input  N  parallel load data.
- sin  input  1  serial input bit for shifts.
- q  output  N  register contents.
- sout_l  output  1  q[N-1]; bit leaving on a left shift. Combinational from q.
- sout_r  output  1  q[0]; bit leaving on a right shift. Combinational from q.
- count  output  CNT_W  valid bits remaining since the last load.
- empty  output  1  count == 0. Combinational from count.
- done  output  1  registered one-cycle pulse; last loaded bit has been shifted out.

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-shift): q=0, count=0, done=0; hence empty=1, sout_l=0, sout_r=0. Registers hold reset values while rst=1.
- Reset release: first active edge with rst=0 executes mode normally.
- All operations take effect on the rising clk edge where mode is sampled. Latency is 1 cycle.
- mode=00 (hold): q and count unchanged; done<=0.
- mode=01 (load): q<=din; count<=N; done<=0. A load overrides any shift in progress.
- mode=10 (shift left): q<={q[N-2:0], sin}.
- mode=11 (shift right): q<={sin, q[N-1:1]}.
- Counter on a shift when count>0: count<=count-1.
- Counter on a shift when count==0: data still shifts; count stays 0 (saturating, no wrap to all-ones); done<=0.
- done on a shift: done<=1 only when count==1 before the edge, i.e. on the 1->0 transition. Otherwise done<=0.
- done is therefore high for exactly the one cycle after the Nth shift following a load.
- Shift direction may change between cycles without restriction; the counter decrements regardless of direction.
- Undefined/X mode: treated as hold in RTL; no assertion required.

Optional Feature:
Macro: SHIFT_REGISTER_ROTATE_EN
- Defined:
  - Adds input port `rot` (1 bit), placed after `sin`.
  - On any shift with rot=1, the inserted bit is the bit shifted out: left inserts q[N-1] into bit 0; right inserts q[0] into bit N-1. sin is ignored.
  - Counter and done behave exactly as for a normal shift.
  - rot is ignored in hold and load.
- Not defined:
  - `rot` port absent.
  - Shifts always insert sin.

Test Plan (N=8):
- Async reset: load 8'hA5, then pulse rst between clock edges -> q=0, count=0, empty=1, done=0 immediately, without waiting for a clock edge.
- PISO left: load 8'hB4, then 8 cycles of mode=10 with sin=0 -> sout_l sequence before each edge 1,0,1,1,0,1,0,0; count 8->0; done=1 for exactly the cycle after the 8th shift; q=0.
- SIPO right: load 8'h00, then 8 right shifts with sin sequence 1,0,0,0,0,0,0,1 -> q=8'h81, count=0, done pulse once.
- Saturation and reload: after count reaches 0, 3 further shifts -> count stays 0, done stays 0. Then load 8'h3C mid-sequence -> q=8'h3C, count=8, done=0.
- Hold and interrupt: load 8'hF0, shift left twice, hold 4 cycles, shift left once -> q=8'h80 after the 3rd shift, count=5, q unchanged during hold.
- Rotate (macro defined): load 8'h81, 1 right shift with rot=1 -> q=8'hC0. Then 8 left shifts with rot=1 -> q=8'hC0; done asserted once after the 8th total shift since the load.
